// File: rtl/if_slave_pipe_if.sv
// mux_if: operand/select bundle between the master-side driver and the
// pipelined responder (if_slave_pipe). Both ends share one clock domain.
interface mux_if #(
  parameter int DATA_WITH = 8
);
  logic [DATA_WITH-1:0] i_a;
  logic [DATA_WITH-1:0] i_b;
  logic                 i_sel;
  logic [DATA_WITH-1:0] o_y;

  modport slave_ports (
    input  i_a,
    input  i_b,
    input  i_sel,
    output o_y
  );

  modport master_ports (
    output i_a,
    output i_b,
    output i_sel,
    input  o_y
  );
endinterface

// File: rtl/if_slave_pipe.sv
// Responder end of mux_if: registered operand select through a LATENCY-deep
// stallable pipeline, valid tracking, fill FSM and saturating select-change count.
// Optional macro IF_SLAVE_PIPE_PARITY_EN adds o_parity pipelined alongside o_y.
module if_slave_pipe #(
  parameter int DATA_WITH = 8,
  parameter int LATENCY   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_clr,
  mux_if.slave_ports           slave_if,
  output logic                 o_valid,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_sel_changes
`ifdef IF_SLAVE_PIPE_PARITY_EN
  ,
  output logic                 o_parity
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [3:0] FILL_LAST = 4'(LATENCY - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [DATA_WITH-1:0] data_p_q [LATENCY];
  logic [DATA_WITH-1:0] data_p_d [LATENCY];
  logic [LATENCY-1:0]   vld_p_q, vld_p_d;
  state_t               state_q, state_d;
  logic [3:0]           fill_q, fill_d;
  logic                 sel_hist_q, sel_hist_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WITH-1:0] sel_operand;
  logic                 sel_change;

  // Operand selection feeds stage 0 only; the enable gate keeps unknown
  // interface values out of the pipeline while stalled.
  assign sel_operand = slave_if.i_sel ? slave_if.i_b : slave_if.i_a;
  assign sel_change  = i_en && vld_p_q[0] && (slave_if.i_sel != sel_hist_q);

  always_comb begin
    data_p_d = data_p_q;
    vld_p_d  = vld_p_q;
    if (i_en) begin
      data_p_d[0] = sel_operand;
      vld_p_d[0]  = 1'b1;
      for (int k = 1; k < LATENCY; k++) begin
        data_p_d[k] = data_p_q[k-1];
        vld_p_d[k]  = vld_p_q[k-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (i_en) begin
      case (state_q)
        IDLE: begin
          if (LATENCY == 1) begin
            state_d = STREAM;
          end else begin
            state_d = FILL;
            fill_d  = 4'd1;
          end
        end
        FILL: begin
          if (fill_q == FILL_LAST) state_d = STREAM;
          else                     fill_d  = fill_q + 4'd1;
        end
        STREAM: state_d = STREAM;
        default: state_d = IDLE;
      endcase
    end
  end

  // Clear beats a same-cycle increment; history still tracks the sample.
  always_comb begin
    sel_hist_d = i_en ? slave_if.i_sel : sel_hist_q;
    cnt_d      = cnt_q;
    if (i_clr)           cnt_d = '0;
    else if (sel_change) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < LATENCY; k++) data_p_q[k] <= '0;
      vld_p_q    <= '0;
      state_q    <= IDLE;
      fill_q     <= '0;
      sel_hist_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      data_p_q   <= data_p_d;
      vld_p_q    <= vld_p_d;
      state_q    <= state_d;
      fill_q     <= fill_d;
      sel_hist_q <= sel_hist_d;
      cnt_q      <= cnt_d;
    end
  end

  assign slave_if.o_y  = data_p_q[LATENCY-1];
  assign o_valid       = vld_p_q[LATENCY-1];
  assign o_state       = state_q;
  assign o_sel_changes = cnt_q;

`ifdef IF_SLAVE_PIPE_PARITY_EN
  logic [LATENCY-1:0] par_p_q, par_p_d;

  // Parity rides its own stages so it stays aligned with o_y.
  always_comb begin
    par_p_d = par_p_q;
    if (i_en) begin
      par_p_d[0] = ^sel_operand;
      for (int k = 1; k < LATENCY; k++) par_p_d[k] = par_p_q[k-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) par_p_q <= '0;
    else       par_p_q <= par_p_d;
  end

  assign o_parity = par_p_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_if_slave_pipe.sv
// Bench for if_slave_pipe: three configurations driven in lockstep, checked
// against a sample-history reference model.
module tb_if_slave_pipe;

  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{2, 1, 4};
  localparam int CW  [NDUT] = '{4, 16, 8};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] a   = 8'h00;
  logic [7:0] b   = 8'h00;
  logic       sel = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux_if #(.DATA_WITH(8)) bus0 ();
  mux_if #(.DATA_WITH(8)) bus1 ();
  mux_if #(.DATA_WITH(8)) bus2 ();

  assign bus0.i_a = a;  assign bus0.i_b = b;  assign bus0.i_sel = sel;
  assign bus1.i_a = a;  assign bus1.i_b = b;  assign bus1.i_sel = sel;
  assign bus2.i_a = a;  assign bus2.i_b = b;  assign bus2.i_sel = sel;

  logic        vld_o [NDUT];
  logic [1:0]  st_o  [NDUT];
  logic [3:0]  cnt0;
  logic [15:0] cnt1;
  logic [7:0]  cnt2;
  logic [31:0] cnt_o [NDUT];
  logic [7:0]  y_o   [NDUT];
  logic        par_o [NDUT];

  assign cnt_o[0] = 32'(cnt0);
  assign cnt_o[1] = 32'(cnt1);
  assign cnt_o[2] = 32'(cnt2);
  assign y_o[0]   = bus0.o_y;
  assign y_o[1]   = bus1.o_y;
  assign y_o[2]   = bus2.o_y;

`ifndef IF_SLAVE_PIPE_PARITY_EN
  assign par_o[0] = 1'b0;
  assign par_o[1] = 1'b0;
  assign par_o[2] = 1'b0;
`endif

  if_slave_pipe #(.DATA_WITH(8), .LATENCY(2), .CNT_WIDTH(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .slave_if(bus0.slave_ports),
    .o_valid(vld_o[0]), .o_state(st_o[0]), .o_sel_changes(cnt0)
`ifdef IF_SLAVE_PIPE_PARITY_EN
    , .o_parity(par_o[0])
`endif
  );

  if_slave_pipe #(.DATA_WITH(8), .LATENCY(1), .CNT_WIDTH(16)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .slave_if(bus1.slave_ports),
    .o_valid(vld_o[1]), .o_state(st_o[1]), .o_sel_changes(cnt1)
`ifdef IF_SLAVE_PIPE_PARITY_EN
    , .o_parity(par_o[1])
`endif
  );

  if_slave_pipe #(.DATA_WITH(8), .LATENCY(4), .CNT_WIDTH(8)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_clr(clr), .slave_if(bus2.slave_ports),
    .o_valid(vld_o[2]), .o_state(st_o[2]), .o_sel_changes(cnt2)
`ifdef IF_SLAVE_PIPE_PARITY_EN
    , .o_parity(par_o[2])
`endif
  );

  // Reference model: newest enabled sample at hist[k][0]; n_en counts enabled
  // edges since reset (capped), which alone decides valid, state and output.
  logic [7:0]  hist  [NDUT][8];
  int          n_en  [NDUT];
  logic        seen  [NDUT];
  logic        prev  [NDUT];
  logic [31:0] m_cnt [NDUT];

  function automatic logic [31:0] cnt_max(input int k);
    return (32'd1 << CW[k]) - 32'd1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      n_en[k]  = 0;
      seen[k]  = 1'b0;
      prev[k]  = 1'b0;
      m_cnt[k] = 32'd0;
      for (int i = 0; i < 8; i++) hist[k][i] = 8'h00;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      if (clr) m_cnt[k] = 32'd0;
      else if (en && seen[k] && (sel != prev[k]) && (m_cnt[k] < cnt_max(k)))
        m_cnt[k] = m_cnt[k] + 32'd1;
      if (en) begin
        for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = sel ? b : a;
        seen[k] = 1'b1;
        prev[k] = sel;
        if (n_en[k] < 100) n_en[k] = n_en[k] + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
  endtask

  task automatic check_all();
    logic [7:0]  ey;
    logic [31:0] est;
    for (int k = 0; k < NDUT; k++) begin
      ey  = (n_en[k] >= LAT[k]) ? hist[k][LAT[k]-1] : 8'h00;
      est = (n_en[k] == 0) ? 32'd0 : (n_en[k] < LAT[k]) ? 32'd1 : 32'd2;
      check($sformatf("y%0d", k),     32'(y_o[k]),   32'(ey));
      check($sformatf("valid%0d", k), 32'(vld_o[k]), (n_en[k] >= LAT[k]) ? 32'd1 : 32'd0);
      check($sformatf("state%0d", k), 32'(st_o[k]),  est);
      check($sformatf("cnt%0d", k),   cnt_o[k],      m_cnt[k]);
`ifdef IF_SLAVE_PIPE_PARITY_EN
      check($sformatf("par%0d", k),   32'(par_o[k]), 32'(^ey));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic e, input logic c, input logic [7:0] va,
                       input logic [7:0] vb, input logic s);
    en = e; clr = c; a = va; b = vb; sel = s;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all();

    drive(1, 0, 8'h11, 8'h22, 0);
    repeat (5) step();

    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 8'hA5, 8'h5A, i[0]);
      step();
    end

    drive(0, 0, 8'hFF, 8'hFF, 1'bx);
    repeat (3) step();
    a = 8'hxx; b = 8'hxx;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 8'h30 + 8'(i), 8'hC0 + 8'(i), i[0]);
      step();
    end

    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 8'h03, 8'h07, ~sel);
      step();
    end
    drive(1, 1, 8'h03, 8'h07, ~sel);
    step();
    drive(1, 0, 8'h03, 8'h07, ~sel);
    step();
    drive(0, 1, 8'h03, 8'h07, sel);
    step();

    drive(1, 0, 8'h03, 8'h07, 1);
    repeat (5) step();
    drive(1, 0, 8'h03, 8'h07, 0);
    repeat (5) step();

    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            8'($urandom), 8'($urandom), 1'($urandom));
      step();
    end

    @(posedge clk);
    model_edge();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b0;
    drive(1, 0, 8'h11, 8'h22, 1);
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_slave_pipe.md
Name: if_slave_pipe

Overview:
Responder end of the mux_if interface. Takes the slave modport, samples i_a/i_b/i_sel each enabled cycle, and returns the selected operand on o_y through a configurable-depth register pipeline. Provides stall (enable), a valid indication, and a saturating select-change counter for interface sanity checks. Sits opposite the master-side driver of mux_if, both sharing one clock domain.

Parameters:
DATA_WITH, 8, operand/result width; must match the mux_if instance.
LATENCY, 2, pipeline depth in cycles, legal 1..8.
CNT_WIDTH, 16, width of the select-change counter.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  asynchronous reset, active-high.
i_en  input  1  pipeline advance; 0 = stall, all stages hold.
i_clr  input  1  synchronous clear of the change counter.
slave_if  interface  -  mux_if.slave_ports: input i_a, input i_b, input i_sel, output o_y.
o_valid  output  1  slave_if.o_y holds a result computed from sampled inputs.
o_state  output  2  FSM state: 0 IDLE, 1 FILL, 2 STREAM.
o_sel_changes  output  CNT_WIDTH  count of enabled samples where i_sel differed from the previous enabled sample.

Behaviour:
- Reset (async, i_rst=1): all data stages 0, all valid bits 0, o_y=0, o_valid=0, o_state=IDLE, o_sel_changes=0, sel history register=0.
- Datapath: stage0 <= i_sel ? i_b : i_a; stage k <= stage k-1; o_y = last stage. Registered only; no combinational path from interface inputs to o_y.
- Latency: result of inputs sampled at edge N (i_en=1) appears on o_y after edge N+LATENCY-1, i.e. LATENCY enabled edges total from sampling.
- Stall: i_en=0 freezes every data stage, every valid bit, and the sel history; o_y and o_valid hold. Counting applies only to enabled cycles.
- Valid: parallel shift register of LATENCY bits; a 1 is shifted in on every enabled edge after reset; o_valid = last bit.
- FSM (advances only when i_en=1):
  IDLE -> FILL on first enabled edge after reset (LATENCY=1: IDLE -> STREAM directly).
  FILL: internal fill counter 1..LATENCY-1 increments per enabled edge; -> STREAM when the count reaches LATENCY-1 (the edge at which o_valid becomes 1).
  STREAM: stays; only reset leaves it.
  o_state==STREAM iff o_valid==1.
- Select-change counter: on an enabled edge where i_sel != sel history and the sample is not the first after reset, increment; saturate at 2^CNT_WIDTH-1 (no wrap). Sel history <= i_sel on every enabled edge.
- i_clr: counter <= 0 at next edge regardless of i_en; i_clr wins over a same-cycle increment (the increment is dropped, sel history still updates if i_en=1).
- Reset mid-stream: immediate return to reset values; in-flight data is discarded and FILL restarts.
- Unknown inputs on the interface while i_en=0 must not propagate.

Optional Feature:
Macro IF_SLAVE_PIPE_PARITY_EN. Defined: adds output port o_parity (1 bit) = even parity (XOR reduction) of stage0 data, pipelined alongside the data so it always matches the current o_y; resets to 0, stalls with i_en. Not defined: port and parity stages absent; all other behaviour identical.

Test Plan:
- Reset then LATENCY=2, i_en=1, i_a=8'h11, i_b=8'h22, i_sel=0 -> o_valid rises after 2nd enabled edge, o_y=8'h11, o_state: IDLE, FILL, STREAM.
- Streaming: i_sel alternating 0,1,0,1 with i_a=8'hA5, i_b=8'h5A -> o_y A5,5A,A5,5A delayed 2 cycles; o_sel_changes=3.
- Stall: i_en=0 for 3 cycles mid-stream while inputs change to 8'hFF -> o_y, o_valid, o_sel_changes unchanged; resume -> prior pipeline contents emerge in order.
- Saturation: CNT_WIDTH=4, toggle i_sel 20 enabled cycles -> counter sticks at 15; assert i_clr with a toggle in the same cycle -> counter 0.
- Async reset asserted mid-STREAM between edges -> o_y=0, o_valid=0, o_state=IDLE immediately; refill takes LATENCY edges.
- With IF_SLAVE_PIPE_PARITY_EN, i_b=8'h07, i_sel=1 -> o_parity=1 aligned with o_y=8'h07; i_a=8'h03, i_sel=0 -> o_parity=0.
